// File: rtl/program_loader.sv
// program_loader: streams a program image into instruction memory while
// holding the core in reset, then runs the core for a bounded cycle budget
// and reports done / fail (error_flag) / truncated image status.
module program_loader #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned CLEAR_ON_LOAD = 1,
  parameter int unsigned RUN_CYCLES    = 100,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_load_start,
  input  logic                  i_load_valid,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_load_last,
  output logic                  o_load_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wdata,
  output logic                  o_core_hold,
  input  logic                  i_error_flag,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fail,
  output logic                  o_truncated,
  output logic [ADDR_WIDTH:0]   o_words_loaded,
  output logic [CNT_WIDTH-1:0]  o_cycles_run
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned WL_W  = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [WL_W-1:0]       LAST_IDX  = WL_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  RUN_LIMIT = CNT_WIDTH'(RUN_CYCLES);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_DONE,
    S_FAIL
  } state_t;

  state_t                r_state;
  logic                  r_load_ready;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [DATA_WIDTH-1:0] r_imem_wdata;
  logic                  r_core_hold;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_fail;
  logic                  r_truncated;
  logic [WL_W-1:0]       r_words_loaded;
  logic [CNT_WIDTH-1:0]  r_cycles_run;

  logic                  w_accept;
  logic                  w_at_end;
  logic [CNT_WIDTH-1:0]  w_cycles_inc;

  // Beat handshake, full-depth detection and saturating run counter increment
  assign w_accept     = (r_state == S_LOAD) && i_load_valid && r_load_ready;
  assign w_at_end     = (r_words_loaded == LAST_IDX);
  assign w_cycles_inc = (r_cycles_run == CNT_MAX) ? r_cycles_run
                                                  : r_cycles_run + CNT_WIDTH'(1);

  // Sequencer: clear, load, release, run and report, all outputs registered
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state        <= S_IDLE;
      r_load_ready   <= 1'b0;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_core_hold    <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fail         <= 1'b0;
      r_truncated    <= 1'b0;
      r_words_loaded <= '0;
      r_cycles_run   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (i_load_start) begin
            r_done         <= 1'b0;
            r_fail         <= 1'b0;
            r_truncated    <= 1'b0;
            r_words_loaded <= '0;
            r_cycles_run   <= '0;
            r_busy         <= 1'b1;
            if (CLEAR_ON_LOAD != 0) begin
              r_state      <= S_CLEAR;
              r_imem_we    <= 1'b1;
              r_imem_addr  <= '0;
              r_imem_wdata <= '0;
            end else begin
              r_state      <= S_LOAD;
              r_load_ready <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (r_imem_addr == LAST_ADDR) begin
            r_state      <= S_LOAD;
            r_imem_we    <= 1'b0;
            r_load_ready <= 1'b1;
          end else begin
            r_imem_addr <= r_imem_addr + ADDR_WIDTH'(1);
          end
        end
        S_LOAD: begin
          r_imem_we <= w_accept;
          if (w_accept) begin
            r_imem_addr    <= r_words_loaded[ADDR_WIDTH-1:0];
            r_imem_wdata   <= i_load_data;
            r_words_loaded <= r_words_loaded + WL_W'(1);
            if (i_load_last || w_at_end) begin
              r_state      <= S_RELEASE;
              r_load_ready <= 1'b0;
              r_truncated  <= !i_load_last;
            end
          end
        end
        S_RELEASE: begin
          r_state     <= S_RUN;
          r_imem_we   <= 1'b0;
          r_core_hold <= 1'b0;
        end
        S_RUN: begin
          if (i_error_flag) begin
            r_state     <= S_FAIL;
            r_fail      <= 1'b1;
            r_core_hold <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cycles_run <= w_cycles_inc;
            if (w_cycles_inc >= RUN_LIMIT) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_core_hold <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_core_hold <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_load_ready   = r_load_ready;
  assign o_imem_we      = r_imem_we;
  assign o_imem_addr    = r_imem_addr;
  assign o_imem_wdata   = r_imem_wdata;
  assign o_core_hold    = r_core_hold;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_fail         = r_fail;
  assign o_truncated    = r_truncated;
  assign o_words_loaded = r_words_loaded;
  assign o_cycles_run   = r_cycles_run;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances, one without clear
// (depth 256, 100-cycle run) and one with clear (depth 16, 10-cycle run).
module tb_program_loader;

  logic        clk;
  logic        rst_n;
  logic        a_start;
  logic        b_start;
  logic        valid;
  logic [15:0] data;
  logic        last;
  logic        err;

  logic        a_ready, a_we, a_hold, a_busy, a_done, a_fail, a_trunc;
  logic [7:0]  a_addr;
  logic [15:0] a_wdata;
  logic [8:0]  a_words;
  logic [15:0] a_cycles;

  logic        b_ready, b_we, b_hold, b_busy, b_done, b_fail, b_trunc;
  logic [3:0]  b_addr;
  logic [15:0] b_wdata;
  logic [4:0]  b_words;
  logic [15:0] b_cycles;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t log_a[$];
  wr_t log_b[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int k;

  program_loader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .CLEAR_ON_LOAD(0), .RUN_CYCLES(100), .CNT_WIDTH(16)
  ) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_load_start(a_start), .i_load_valid(valid),
    .i_load_data(data), .i_load_last(last), .o_load_ready(a_ready), .o_imem_we(a_we),
    .o_imem_addr(a_addr), .o_imem_wdata(a_wdata), .o_core_hold(a_hold),
    .i_error_flag(err), .o_busy(a_busy), .o_done(a_done), .o_fail(a_fail),
    .o_truncated(a_trunc), .o_words_loaded(a_words), .o_cycles_run(a_cycles)
  );

  program_loader #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_ON_LOAD(1), .RUN_CYCLES(10), .CNT_WIDTH(16)
  ) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_load_start(b_start), .i_load_valid(valid),
    .i_load_data(data), .i_load_last(last), .o_load_ready(b_ready), .o_imem_we(b_we),
    .o_imem_addr(b_addr), .o_imem_wdata(b_wdata), .o_core_hold(b_hold),
    .i_error_flag(err), .o_busy(b_busy), .o_done(b_done), .o_fail(b_fail),
    .o_truncated(b_trunc), .o_words_loaded(b_words), .o_cycles_run(b_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory write monitor: a write commits on the edge where imem_we is seen high
  always @(posedge clk) begin
    if (a_we === 1'b1) log_a.push_back({a_addr, a_wdata});
    if (b_we === 1'b1) log_b.push_back({8'(b_addr), b_wdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; a_start = 1'b0; b_start = 1'b0;
    valid = 1'b0; data = '0; last = 1'b0; err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_hold", 32'(a_hold), 1);
    check("rst_a_ready", 32'(a_ready), 0);
    check("rst_a_we", 32'(a_we), 0);
    check("rst_a_status", {a_busy, a_done, a_fail, a_trunc}, 0);
    check("rst_b_hold", 32'(b_hold), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Normal 5-word load, no clear, 100-cycle run
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_ready_first", 32'(a_ready), 1);
    check("a_busy_load", 32'(a_busy), 1);
    log_a.delete();
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; data = 16'(16'h1001 + i); last = (i == 4);
      tick();
      check("a_we_beat", 32'(a_we), 1);
      check("a_addr_beat", 32'(a_addr), 32'(i));
      check("a_wdata_beat", 32'(a_wdata), 32'(16'h1001 + i));
    end
    valid = 1'b0; last = 1'b0;
    check("a_ready_drop", 32'(a_ready), 0);
    check("a_words5", 32'(a_words), 5);
    check("a_hold_release", 32'(a_hold), 1);
    tick();
    check("a_log5", 32'(log_a.size()), 5);
    check("a_hold_run", 32'(a_hold), 0);
    check("a_we_idle_run", 32'(a_we), 0);
    n = 0;
    while (a_hold === 1'b0 && n < 300) begin
      tick();
      n++;
    end
    check("a_run_len", 32'(n), 100);
    check("a_done", 32'(a_done), 1);
    check("a_fail_clear", 32'(a_fail), 0);
    check("a_cycles100", 32'(a_cycles), 100);
    check("a_busy_done", 32'(a_busy), 0);

    // Error at run cycle 37
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_restart_done", 32'(a_done), 0);
    check("a_restart_words", 32'(a_words), 0);
    check("a_restart_cycles", 32'(a_cycles), 0);
    valid = 1'b1; data = 16'h5555; last = 1'b0;
    tick();
    data = 16'h6666; last = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0;
    n = 0;
    while (a_cycles !== 16'd37 && n < 300) begin
      tick();
      n++;
    end
    check("a_reach37", 32'(a_cycles), 37);
    check("a_hold_before_err", 32'(a_hold), 0);
    err = 1'b1;
    tick();
    err = 1'b0;
    check("a_fail", 32'(a_fail), 1);
    check("a_done_on_fail", 32'(a_done), 0);
    check("a_cycles_err", 32'(a_cycles), 37);
    check("a_hold_err", 32'(a_hold), 1);
    tick();
    check("a_cycles_frozen", 32'(a_cycles), 37);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_fail_cleared", 32'(a_fail), 0);
    check("a_cycles_cleared", 32'(a_cycles), 0);
    check("a_ready_reload", 32'(a_ready), 1);

    // Backpressure: 8 words with random valid gaps
    log_a.delete();
    k = 0;
    n = 0;
    while (k < 8 && n < 200) begin
      valid = 1'($urandom_range(0, 1));
      data = 16'(16'h2000 + k);
      last = (k == 7);
      tick();
      if (valid) k++;
      n++;
    end
    valid = 1'b0; last = 1'b0;
    tick();
    check("bp_accepts", 32'(k), 8);
    check("bp_log_size", 32'(log_a.size()), 8);
    for (int i = 0; i < 8 && i < log_a.size(); i++) begin
      check("bp_addr", 32'(log_a[i].addr), 32'(i));
      check("bp_data", 32'(log_a[i].data), 32'(16'h2000 + i));
    end
    check("bp_words", 32'(a_words), 8);
    n = 0;
    while (a_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("bp_done", 32'(a_done), 1);

    // Asynchronous reset mid-LOAD
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    valid = 1'b1; data = 16'h7777; last = 1'b0;
    tick();
    valid = 1'b0;
    check("mid_words1", 32'(a_words), 1);
    check("mid_we", 32'(a_we), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_hold", 32'(a_hold), 1);
    check("mid_rst_ready", 32'(a_ready), 0);
    check("mid_rst_we", 32'(a_we), 0);
    check("mid_rst_status", {a_busy, a_done, a_fail, a_trunc}, 0);
    check("mid_rst_words", 32'(a_words), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_idle_ready", 32'(a_ready), 0);
    check("mid_idle_busy", 32'(a_busy), 0);

    // Clear sweep on depth-16 instance, then 2-word load
    log_b.delete();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("clr_we_first", 32'(b_we), 1);
    check("clr_addr_first", 32'(b_addr), 0);
    check("clr_ready_low", 32'(b_ready), 0);
    n = 0;
    while (b_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("clr_cycles", 32'(n), 16);
    check("clr_log_size", 32'(log_b.size()), 16);
    for (int i = 0; i < 16 && i < log_b.size(); i++) begin
      check("clr_addr", 32'(log_b[i].addr), 32'(i));
      check("clr_data", 32'(log_b[i].data), 0);
    end
    valid = 1'b1; data = 16'hAAAA; last = 1'b0;
    tick();
    data = 16'hBBBB; last = 1'b1;
    tick();
    valid = 1'b0; last = 1'b0;
    tick();
    check("ld2_log_size", 32'(log_b.size()), 18);
    if (log_b.size() >= 18) begin
      check("ld2_w0", {8'(log_b[16].addr), log_b[16].data}, {8'h0, 16'hAAAA});
      check("ld2_w1", {8'(log_b[17].addr), log_b[17].data}, {8'h1, 16'hBBBB});
    end
    n = 0;
    while (b_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("ld2_done", 32'(b_done), 1);
    check("ld2_cycles", 32'(b_cycles), 10);
    check("ld2_trunc", 32'(b_trunc), 0);

    // Truncation: 18 words without last into depth 16
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    n = 0;
    while (b_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    log_b.delete();
    for (int i = 0; i < 18; i++) begin
      valid = 1'b1; data = 16'(16'h3000 + i); last = 1'b0;
      tick();
      if (i == 14) check("tr_ready_15", 32'(b_ready), 1);
      if (i == 15) begin
        check("tr_ready_drop", 32'(b_ready), 0);
        check("tr_flag", 32'(b_trunc), 1);
        check("tr_words", 32'(b_words), 16);
      end
      if (i == 16) check("tr_run_starts", 32'(b_hold), 0);
    end
    valid = 1'b0;
    check("tr_log_size", 32'(log_b.size()), 16);
    for (int i = 0; i < 16 && i < log_b.size(); i++) begin
      check("tr_entry", {8'(log_b[i].addr), log_b[i].data}, {8'(i), 16'(16'h3000 + i)});
    end
    n = 0;
    while (b_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("tr_done", 32'(b_done), 1);
    check("tr_flag_held", 32'(b_trunc), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
